// File: rtl/fir_sched_pkg.sv
// Shared definitions for the FIR channel scheduler: FSM encoding, channel
// indices, default sizes and the enabled-channel search helper.
package fir_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;

  localparam int DW_DEF  = 12;
  localparam int NCH_DEF = 3;
  localparam int TMO_DEF = 255;

  // Lowest enabled channel index >= from; bit 2 flags that one was found.
  function automatic logic [2:0] find_ch(input logic [2:0] en, input logic [1:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (en[i] && (i >= int'(from))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/fs_edge_sync.sv
// Brings the asynchronous f_s level into the clk domain and emits a one-cycle
// tick on its rising edge (tick appears 3 clk cycles after the f_s rise).
module fs_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic f_s,
  output logic tick
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      tick <= 1'b0;
    end else begin
      s1   <= f_s;
      s2   <= s1;
      s3   <= s2;
      tick <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/fir_ch_sched.sv
// Time-shares one FIR engine across three channels: each f_s frame snapshots
// the inputs and issues the enabled channels in ascending order.
module fir_ch_sched
  import fir_sched_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int NCH = NCH_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_s,
  input  logic [NCH-1:0]       ch_en,
  input  logic signed [DW-1:0] din_a,
  input  logic signed [DW-1:0] din_b,
  input  logic signed [DW-1:0] din_c,
  output logic                 fir_start,
  output logic [1:0]           fir_ch,
  output logic signed [DW-1:0] fir_din,
  input  logic                 fir_done,
  input  logic signed [DW-1:0] fir_dout,
  output logic signed [DW-1:0] dout_a,
  output logic signed [DW-1:0] dout_b,
  output logic signed [DW-1:0] dout_c,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  localparam int CW = $clog2(TMO + 1);

  state_t               state, state_nx;
  logic                 tick;
  logic [NCH-1:0]       snap_en;
  logic signed [DW-1:0] snap_a, snap_b, snap_c;
  logic [CW-1:0]        wd;
  logic [2:0]           first, nxt;
  logic                 tmo_hit, ch_end;

  function automatic logic signed [DW-1:0] pick(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b,
                                                input logic signed [DW-1:0] c,
                                                input logic [1:0] idx);
    logic signed [DW-1:0] r;
    case (idx)
      CH_A:    r = a;
      CH_B:    r = b;
      default: r = c;
    endcase
    return r;
  endfunction

  fs_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .f_s  (f_s),
    .tick (tick)
  );

  assign first   = find_ch(ch_en, 2'd0);
  assign nxt     = find_ch(snap_en, fir_ch + 2'd1);
  // wd holds cycles elapsed since fir_start; a done in the deadline cycle still wins
  assign tmo_hit = (wd == CW'(TMO - 1));
  assign ch_end  = (state == WAIT) && (fir_done || tmo_hit);

  assign fir_start  = (state == ISSUE);
  assign dout_valid = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = LATCH;
      LATCH:   state_nx = first[2] ? ISSUE : DONE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (ch_end) state_nx = nxt[2] ? ISSUE : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_en     <= '0;
      snap_a      <= '0;
      snap_b      <= '0;
      snap_c      <= '0;
      fir_ch      <= CH_A;
      fir_din     <= '0;
      wd          <= '0;
      dout_a      <= '0;
      dout_b      <= '0;
      dout_c      <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        LATCH: begin
          snap_en <= ch_en;
          snap_a  <= din_a;
          snap_b  <= din_b;
          snap_c  <= din_c;
          if (first[2]) begin
            fir_ch  <= first[1:0];
            fir_din <= pick(din_a, din_b, din_c, first[1:0]);
          end
        end
        ISSUE: wd <= CW'(1);
        WAIT: begin
          wd <= wd + 1'b1;
          if (fir_done) begin
            case (fir_ch)
              CH_A:    dout_a <= fir_dout;
              CH_B:    dout_b <= fir_dout;
              default: dout_c <= fir_dout;
            endcase
          end
          if (ch_end && nxt[2]) begin
            fir_ch  <= nxt[1:0];
            fir_din <= pick(snap_a, snap_b, snap_c, nxt[1:0]);
          end
        end
        default: ;
      endcase

      if (ch_end && !fir_done) timeout_err <= 1'b1;
      else if (err_clr)        timeout_err <= 1'b0;

      if (tick && (state != IDLE)) overrun <= 1'b1;
      else if (err_clr)            overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_ch_sched.sv
// Directed bench for fir_ch_sched with a behavioural FIR engine that returns
// din/2 after a programmable latency (or never, for one selected channel).
module tb_fir_ch_sched;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_s;
  logic [2:0]        ch_en;
  logic signed [11:0] din_a, din_b, din_c;
  logic              fir_start;
  logic [1:0]        fir_ch;
  logic signed [11:0] fir_din;
  logic              fir_done;
  logic signed [11:0] fir_dout;
  logic signed [11:0] dout_a, dout_b, dout_c;
  logic              dout_valid, busy, overrun, timeout_err;
  logic              err_clr;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // engine model state
  int         lat = 20;
  logic       skip_en = 1'b0;
  logic [1:0] skip_ch = 2'd1;
  logic       eng_flush = 1'b0;
  logic       pend;
  int         cnt;
  logic [1:0] ech;
  int         nst;
  int         st_ch [64];
  int         st_din[64];
  int         st_cyc[64];
  int         done_cyc = -1;

  // dout_valid monitor
  int vcount = 0;
  int vcyc   = -1;

  fir_ch_sched #(.DW(12), .NCH(3), .TMO(255)) dut (
    .clk         (clk),
    .rst         (rst),
    .f_s         (f_s),
    .ch_en       (ch_en),
    .din_a       (din_a),
    .din_b       (din_b),
    .din_c       (din_c),
    .fir_start   (fir_start),
    .fir_ch      (fir_ch),
    .fir_din     (fir_din),
    .fir_done    (fir_done),
    .fir_dout    (fir_dout),
    .dout_a      (dout_a),
    .dout_b      (dout_b),
    .dout_c      (dout_c),
    .dout_valid  (dout_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    fir_done = 1'b0;
    fir_dout = '0;
    pend = 1'b0;
    cnt = 0;
    ech = 2'd0;
    nst = 0;
    forever begin
      @(posedge clk);
      #1;
      fir_done = 1'b0;
      if (rst || eng_flush) pend = 1'b0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 1'b0;
          if (!(skip_en && ech == skip_ch)) begin
            fir_done = 1'b1;
            fir_dout = fir_din >>> 1;
            done_cyc = cyc;
          end
        end
      end
      if (fir_start && !rst) begin
        pend = 1'b1;
        cnt = lat;
        ech = fir_ch;
        if (nst < 64) begin
          st_ch[nst]  = int'(fir_ch);
          st_din[nst] = int'(fir_din);
          st_cyc[nst] = cyc;
        end
        nst++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (dout_valid) begin
        vcount++;
        vcyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic wait_valid(input int target, input int budget, input string tag);
    int n = 0;
    while (vcount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, vcount, target);
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n = 0;
    while (nst < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, nst, target);
  endtask

  task automatic fs_pulse(output int c);
    @(negedge clk);
    f_s = 1'b1;
    c = cyc;
    repeat (4) @(negedge clk);
    f_s = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    int c, c2, s, nb, vb;
    rst = 1'b1;
    f_s = 1'b0;
    ch_en = 3'b000;
    din_a = '0;
    din_b = '0;
    din_c = '0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fir_start", fir_start, 0);
    chk("rst_fir_ch", fir_ch, 0);
    chk("rst_fir_din", fir_din, 0);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_dout_b", dout_b, 0);
    chk("rst_dout_c", dout_c, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // all three channels, engine returns din/2 after 20 cycles
    ch_en = 3'b111;
    din_a = 12'sd100;
    din_b = -12'sd200;
    din_c = 12'sd300;
    fs_pulse(c);
    wait_valid(1, 400, "a_valid_wait");
    chk("a_nstarts", nst, 3);
    chk("a_ch0", st_ch[0], 0);
    chk("a_ch1", st_ch[1], 1);
    chk("a_ch2", st_ch[2], 2);
    chk("a_din0", st_din[0], 100);
    chk("a_din1", st_din[1], -200);
    chk("a_din2", st_din[2], 300);
    chk("a_first_start_cyc", st_cyc[0], c + 5);
    chk("a_dout_a", dout_a, 50);
    chk("a_dout_b", dout_b, -100);
    chk("a_dout_c", dout_c, 150);
    chk("a_valid_cyc", vcyc, done_cyc + 1);
    repeat (10) @(negedge clk);
    chk("a_one_valid", vcount, 1);
    chk("a_idle", busy, 0);

    // channels a and c only; ch_en/din_b change mid-frame must not matter
    ch_en = 3'b101;
    din_a = -12'sd8;
    din_b = 12'sd40;
    din_c = -12'sd34;
    fs_pulse(c);
    wait_starts(4, 100, "b_start_wait");
    ch_en = 3'b010;
    din_b = 12'sd41;
    wait_valid(2, 400, "b_valid_wait");
    chk("b_nstarts", nst, 5);
    chk("b_ch_first", st_ch[3], 0);
    chk("b_ch_second", st_ch[4], 2);
    chk("b_din_second", st_din[4], -34);
    chk("b_dout_a", dout_a, -4);
    chk("b_dout_b_hold", dout_b, -100);
    chk("b_dout_c", dout_c, -17);
    chk("b_valid_cyc", vcyc, done_cyc + 1);

    // engine never answers channel b: watchdog fires, channel c still runs
    ch_en = 3'b111;
    din_a = 12'sd10;
    din_b = 12'sd222;
    din_c = -12'sd6;
    skip_en = 1'b1;
    skip_ch = 2'd1;
    fs_pulse(c);
    wait_starts(7, 200, "c_start_wait");
    chk("c_hung_ch", st_ch[6], 1);
    s = st_cyc[6];
    while (cyc < s + 254) @(negedge clk);
    chk("c_tmo_not_yet", timeout_err, 0);
    @(negedge clk);
    chk("c_tmo_set", timeout_err, 1);
    chk("c_next_start", fir_start, 1);
    chk("c_next_ch", fir_ch, 2);
    wait_valid(3, 200, "c_valid_wait");
    chk("c_dout_a", dout_a, 5);
    chk("c_dout_b_hold", dout_b, -100);
    chk("c_dout_c", dout_c, -3);
    chk("c_tmo_sticky", timeout_err, 1);
    clear_errs();
    chk("c_tmo_cleared", timeout_err, 0);
    skip_en = 1'b0;

    // done in the deadline cycle is accepted; one cycle later it is ignored
    ch_en = 3'b001;
    lat = 254;
    din_a = 12'sd64;
    fs_pulse(c);
    wait_valid(4, 600, "d_valid_wait");
    chk("d_edge_dout_a", dout_a, 32);
    chk("d_edge_no_tmo", timeout_err, 0);
    lat = 255;
    din_a = -12'sd90;
    fs_pulse(c);
    wait_valid(5, 600, "d_late_valid_wait");
    repeat (3) @(negedge clk);
    chk("d_late_dout_a_hold", dout_a, 32);
    chk("d_late_tmo", timeout_err, 1);
    clear_errs();
    chk("d_late_tmo_cleared", timeout_err, 0);

    // f_s edge while busy: overrun, frame dropped, set beats err_clr
    lat = 3000;
    din_a = 12'sd500;
    nb = nst;
    fs_pulse(c);
    repeat (100) @(negedge clk);
    chk("e_busy", busy, 1);
    chk("e_overrun_before", overrun, 0);
    @(negedge clk);
    f_s = 1'b1;
    c2 = cyc;
    repeat (3) @(negedge clk);
    err_clr = 1'b1;
    chk("e_overrun_at_tick", overrun, 0);
    @(negedge clk);
    err_clr = 1'b0;
    chk("e_overrun_set_wins", overrun, 1);
    f_s = 1'b0;
    wait_valid(6, 600, "e_valid_wait");
    repeat (30) @(negedge clk);
    chk("e_dropped_frame", nst, nb + 1);
    chk("e_one_valid", vcount, 6);
    chk("e_overrun_sticky", overrun, 1);
    clear_errs();
    chk("e_overrun_cleared", overrun, 0);
    eng_flush = 1'b1;
    @(negedge clk);
    eng_flush = 1'b0;

    // reset while waiting on channel b aborts the frame at once
    lat = 20;
    ch_en = 3'b111;
    din_a = -12'sd2;
    din_b = 12'sd6;
    din_c = 12'sd8;
    nb = nst;
    fs_pulse(c);
    wait_starts(nb + 2, 100, "f_start_wait");
    repeat (5) @(negedge clk);
    chk("f_busy_before", busy, 1);
    chk("f_dout_a_before", dout_a, -1);
    vb = vcount;
    rst = 1'b1;
    #1;
    chk("f_rst_busy", busy, 0);
    chk("f_rst_fir_ch", fir_ch, 0);
    chk("f_rst_fir_din", fir_din, 0);
    chk("f_rst_fir_start", fir_start, 0);
    chk("f_rst_dout_a", dout_a, 0);
    chk("f_rst_dout_b", dout_b, 0);
    chk("f_rst_dout_c", dout_c, 0);
    chk("f_rst_dout_valid", dout_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("f_no_valid_aborted", vcount, vb);
    ch_en = 3'b010;
    din_b = -12'sd1000;
    fs_pulse(c);
    wait_valid(vb + 1, 200, "f_resume_valid_wait");
    chk("f_resume_dout_b", dout_b, -500);
    chk("f_resume_dout_a", dout_a, 0);
    chk("f_resume_ch", st_ch[nst - 1], 1);

    // no channel enabled: no engine start, dout_valid two cycles after tick
    ch_en = 3'b000;
    nb = nst;
    vb = vcount;
    fs_pulse(c);
    wait_valid(vb + 1, 50, "g_valid_wait");
    chk("g_valid_cyc", vcyc, c + 5);
    repeat (5) @(negedge clk);
    chk("g_no_start", nst, nb);
    chk("g_dout_b_hold", dout_b, -500);
    chk("g_one_valid", vcount, vb + 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
